// File: rtl/gpu_bg_line_fetcher_pkg.sv
// Shared definitions for the background line fetcher.
// Contents:
//   - VRAM offsets relative to 0x8000 (tile maps and the signed tile-data base)
//   - LCDC bit positions used by the fetcher
//   - FSM state encoding
//   - tile_row_addr(): VRAM offset of one 2-byte row of a tile
package gpu_bg_line_fetcher_pkg;

    localparam logic [12:0] VRAM_MAP0        = 13'h1800;
    localparam logic [12:0] VRAM_MAP1        = 13'h1C00;
    localparam logic [12:0] VRAM_SIGNED_BASE = 13'h1000;

    localparam int LCDC_BG_EN    = 0;
    localparam int LCDC_MAP_SEL  = 3;
    localparam int LCDC_DATA_SEL = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MAP  = 3'd1,
        ST_LO   = 3'd2,
        ST_HI   = 3'd3,
        ST_PUSH = 3'd4,
        ST_DONE = 3'd5
    } fetch_state_e;

    // Offset of the low byte of row `row` of tile `tile`.
    // unsigned_sel=1: tiles 0..255 from 0x0000. unsigned_sel=0: tiles -128..127
    // around 0x1000, wrapping in 13 bits.
    function automatic logic [12:0] tile_row_addr(input logic [7:0] tile,
                                                  input logic [2:0] row,
                                                  input logic       unsigned_sel);
        logic [12:0] base;
        if (unsigned_sel) begin
            base = {1'b0, tile, 4'b0000};
        end else begin
            base = VRAM_SIGNED_BASE + {tile[7], tile, 4'b0000};
        end
        return base + {9'b0, row, 1'b0};
    endfunction

endpackage

// File: rtl/gpu_bg_line_fetcher_tile_shifter.sv
// 8-pixel shift pair for one tile row.
// Ports:
//   clk_i, rst_ni       clock, async active-low reset
//   load_i              load a new row (load_lo_i / load_hi_i)
//   load_lo_i/hi_i      row bitplanes; bit 7 is the leftmost pixel
//   shift_i             drop the current pixel (may coincide with load_i)
//   pixel_o             current pixel {hi[7], lo[7]}
//   last_o              the current pixel is the final one held
// While load_i is high the row being loaded is shown directly, so the
// first pixel is available in the same cycle the hi byte arrives.
module gpu_tile_shifter (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       load_i,
    input  logic [7:0] load_lo_i,
    input  logic [7:0] load_hi_i,
    input  logic       shift_i,
    output logic [1:0] pixel_o,
    output logic       last_o
);

    logic [7:0] lo_q;
    logic [7:0] hi_q;
    logic [3:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lo_q  <= 8'd0;
            hi_q  <= 8'd0;
            cnt_q <= 4'd0;
        end else if (load_i) begin
            lo_q  <= shift_i ? {load_lo_i[6:0], 1'b0} : load_lo_i;
            hi_q  <= shift_i ? {load_hi_i[6:0], 1'b0} : load_hi_i;
            cnt_q <= shift_i ? 4'd7 : 4'd8;
        end else if (shift_i && cnt_q != 4'd0) begin
            lo_q  <= {lo_q[6:0], 1'b0};
            hi_q  <= {hi_q[6:0], 1'b0};
            cnt_q <= cnt_q - 4'd1;
        end
    end

    assign pixel_o = load_i ? {load_hi_i[7], load_lo_i[7]} : {hi_q[7], lo_q[7]};
    assign last_o  = !load_i && (cnt_q == 4'd1);

endmodule

// File: rtl/gpu_bg_line_fetcher.sv
// Background scanline fetcher: reads tile map + tile data from VRAM and
// streams one line of 2-bit colour indices.
// Ports:
//   iClock, iReset                 clock, async active-low reset
//   iLineStart, iLY, iSCX, iSCY,
//   iLCDC                          line start pulse and parameters (sampled in IDLE)
//   oVramRe, oVramAddr, iVramData  VRAM read port; data returns one cycle after oVramRe
//   oPixel, oPixelValid,
//   iPixelReady                    pixel stream
//   oBusy, oLineDone               status
// Handshake: a pixel transfers on a cycle where oPixelValid and iPixelReady
// are both high; oPixelValid never depends on iPixelReady and oPixel is held
// while valid is high and ready is low.
module gpu_bg_line_fetcher
    import gpu_bg_line_fetcher_pkg::*;
#(
    parameter int PIXELS_PER_LINE = 160,
    parameter int MAP_WIDTH_TILES = 32
) (
    input  logic        iClock,
    input  logic        iReset,
    input  logic        iLineStart,
    input  logic [7:0]  iLY,
    input  logic [7:0]  iSCX,
    input  logic [7:0]  iSCY,
    input  logic [7:0]  iLCDC,
    output logic        oVramRe,
    output logic [12:0] oVramAddr,
    input  logic [7:0]  iVramData,
    output logic [1:0]  oPixel,
    output logic        oPixelValid,
    input  logic        iPixelReady,
    output logic        oBusy,
    output logic        oLineDone
);

    localparam logic [7:0] LAST_PIXEL = 8'(PIXELS_PER_LINE - 1);
    localparam logic [4:0] LAST_TILE  = 5'(MAP_WIDTH_TILES - 1);

    fetch_state_e state_q, state_d;

    logic [7:0]  y_q;
    logic [4:0]  tile_x_q;
    logic [2:0]  discard_q;
    logic        bg_en_q, map_sel_q, data_sel_q;
    logic [7:0]  pix_cnt_q;
    logic [7:0]  lo_q;
    logic [12:0] row_addr_q;
    logic        load_q;          // first PUSH cycle: hi byte is on iVramData

    logic [1:0]  sh_pixel;
    logic        sh_last;
    logic        discarding, pix_valid, accept, shift, line_end, tile_end;
    logic        unused_lcdc_bits;

    assign unused_lcdc_bits = ^{iLCDC[7:5], iLCDC[2:1]};

    // Leading pixels of the first tile are dropped one per cycle before
    // anything is presented. With BG off nothing is fetched or discarded.
    assign discarding = (state_q == ST_PUSH) && bg_en_q && (discard_q != 3'd0);
    assign pix_valid  = (state_q == ST_PUSH) && !discarding;
    assign accept     = pix_valid && iPixelReady;
    assign shift      = (state_q == ST_PUSH) && bg_en_q && (discarding || accept);
    assign line_end   = accept && (pix_cnt_q == LAST_PIXEL);
    assign tile_end   = shift && sh_last;

    gpu_tile_shifter u_shifter (
        .clk_i     (iClock),
        .rst_ni    (iReset),
        .load_i    (load_q),
        .load_lo_i (lo_q),
        .load_hi_i (iVramData),
        .shift_i   (shift),
        .pixel_o   (sh_pixel),
        .last_o    (sh_last)
    );

    // State register
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; reaching the pixel count wins over an emptied tile
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (iLineStart) state_d = iLCDC[LCDC_BG_EN] ? ST_MAP : ST_PUSH;
            ST_MAP:  state_d = ST_LO;
            ST_LO:   state_d = ST_HI;
            ST_HI:   state_d = ST_PUSH;
            ST_PUSH: begin
                if (line_end)      state_d = ST_DONE;
                else if (tile_end) state_d = ST_MAP;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        oVramRe   = 1'b0;
        oVramAddr = 13'd0;
        case (state_q)
            ST_MAP: begin
                oVramRe   = 1'b1;
                oVramAddr = (map_sel_q ? VRAM_MAP1 : VRAM_MAP0)
                          + {3'b000, y_q[7:3], 5'b00000} + {8'd0, tile_x_q};
            end
            ST_LO: begin
                oVramRe   = 1'b1;
                oVramAddr = tile_row_addr(iVramData, y_q[2:0], data_sel_q);
            end
            ST_HI: begin
                oVramRe   = 1'b1;
                oVramAddr = row_addr_q + 13'd1;
            end
            default: ;
        endcase
    end

    assign oPixelValid = pix_valid;
    assign oPixel      = (pix_valid && bg_en_q) ? sh_pixel : 2'b00;
    assign oBusy       = (state_q != ST_IDLE);
    assign oLineDone   = (state_q == ST_DONE);

    // Datapath registers
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            y_q        <= 8'd0;
            tile_x_q   <= 5'd0;
            discard_q  <= 3'd0;
            bg_en_q    <= 1'b0;
            map_sel_q  <= 1'b0;
            data_sel_q <= 1'b0;
            pix_cnt_q  <= 8'd0;
            lo_q       <= 8'd0;
            row_addr_q <= 13'd0;
            load_q     <= 1'b0;
        end else begin
            load_q <= (state_q == ST_HI);
            case (state_q)
                ST_IDLE: if (iLineStart) begin
                    y_q        <= iLY + iSCY;
                    tile_x_q   <= iSCX[7:3];
                    discard_q  <= iSCX[2:0];
                    bg_en_q    <= iLCDC[LCDC_BG_EN];
                    map_sel_q  <= iLCDC[LCDC_MAP_SEL];
                    data_sel_q <= iLCDC[LCDC_DATA_SEL];
                    pix_cnt_q  <= 8'd0;
                end
                ST_LO: row_addr_q <= tile_row_addr(iVramData, y_q[2:0], data_sel_q);
                ST_HI: lo_q <= iVramData;
                ST_PUSH: begin
                    if (discarding) discard_q <= discard_q - 3'd1;
                    if (accept)     pix_cnt_q <= pix_cnt_q + 8'd1;
                    if (tile_end && !line_end) begin
                        tile_x_q <= (tile_x_q == LAST_TILE) ? 5'd0 : tile_x_q + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
